div24_16: RTL and testbench



---
 rtl/div24_16_pkg.sv | 33 +++
 rtl/div24_16_step.sv | 24 ++
 rtl/div24_16.sv | 135 +++++++++++++
 tb/tb_div24_16.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div24_16_pkg.sv
// Shared widths, state encoding and the overflow test for the 24/16 -> 32
// restoring divider that undoes the truncated mantissa multiply.
package div24_16_pkg;

    localparam int IP1WRDLEN = 16;            // divisor width
    localparam int IP2WRDLEN = 32;            // quotient width
    localparam int OPWRDLEN  = 24;            // dividend (truncated product) width
    localparam int SHIFT     = 22;            // product LSBs dropped by the multiplier
    localparam int OVF_SHIFT = IP2WRDLEN - SHIFT;
    localparam int REMLEN    = IP1WRDLEN + 1; // partial remainder needs one guard bit
    localparam int CNTLEN    = 5;

    localparam logic [IP2WRDLEN-1:0] QUOT_SAT  = '1;
    localparam logic [CNTLEN-1:0]    CNT_START = CNTLEN'(IP2WRDLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    // (res << SHIFT) / div needs more than 32 quotient bits exactly when
    // res >= div << OVF_SHIFT.
    function automatic logic quot_overflows(
        input logic [OPWRDLEN-1:0]  res,
        input logic [IP1WRDLEN-1:0] div
    );
        logic [IP1WRDLEN+OVF_SHIFT-1:0] threshold;
        threshold = {div, {OVF_SHIFT{1'b0}}};
        return {{(IP1WRDLEN+OVF_SHIFT-OPWRDLEN){1'b0}}, res} >= threshold;
    endfunction

endpackage

// File: rtl/div24_16_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step
    import div24_16_pkg::*;
(
    input  logic [REMLEN-1:0]    rem_in,
    input  logic [IP1WRDLEN-1:0] divisor,
    input  logic                 bit_in,
    output logic [REMLEN-1:0]    rem_out,
    output logic                 q_bit
);

    logic [REMLEN-1:0] trial;
    logic [REMLEN:0]   diff;

    always_comb begin
        trial   = {rem_in[IP1WRDLEN-1:0], bit_in};
        // The extra MSB of diff is the borrow: set means the divisor did not fit.
        diff    = {1'b0, trial} - {2'b00, divisor};
        q_bit   = ~diff[REMLEN];
        rem_out = q_bit ? diff[REMLEN-1:0] : trial;
    end

endmodule

// File: rtl/div24_16.sv
// Sequential divider recovering op2_32 = floor((res_24 << 22) / op1_16) and the
// remainder, one quotient bit per clock; errors saturate in a single cycle.
module div24_16
    import div24_16_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [OPWRDLEN-1:0]  res_24,
    input  logic [IP1WRDLEN-1:0] op1_16,
    output logic                 busy,
    output logic                 op_valid,
    output logic [IP2WRDLEN-1:0] op2_32,
    output logic [IP1WRDLEN-1:0] rem_16,
    output logic                 div_zero,
    output logic                 ovf
);

    state_t state_reg, state_next;

    logic [REMLEN-1:0]    rem_reg;
    logic [IP2WRDLEN-1:0] shift_reg;
    logic [IP2WRDLEN-1:0] quot_reg;
    logic [IP1WRDLEN-1:0] divisor_reg;
    logic [CNTLEN-1:0]    count_reg;

    logic [IP2WRDLEN-1:0] op2_reg;
    logic [IP1WRDLEN-1:0] rem16_reg;
    logic                 div_zero_reg;
    logic                 ovf_reg;
    logic                 op_valid_reg;

    logic [REMLEN-1:0]    step_rem;
    logic                 step_q;
    logic                 accept;
    logic                 in_zero;
    logic                 in_ovf;

    div_step u_step (
        .rem_in  (rem_reg),
        .divisor (divisor_reg),
        .bit_in  (shift_reg[IP2WRDLEN-1]),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        in_zero    = (op1_16 == '0);
        in_ovf     = quot_overflows(res_24, op1_16);
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (in_zero || in_ovf) ? DONE : DIV;
                end
            end
            DIV: begin
                if (count_reg == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rem_reg      <= '0;
            shift_reg    <= '0;
            quot_reg     <= '0;
            divisor_reg  <= '0;
            count_reg    <= '0;
            op2_reg      <= '0;
            rem16_reg    <= '0;
            div_zero_reg <= 1'b0;
            ovf_reg      <= 1'b0;
            op_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            op_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        divisor_reg <= op1_16;
                        // The top 14 dividend bits are already below the divisor
                        // once overflow is excluded, so the first 32 steps suffice.
                        rem_reg     <= {{(REMLEN-(OPWRDLEN-OVF_SHIFT)){1'b0}},
                                        res_24[OPWRDLEN-1:OVF_SHIFT]};
                        shift_reg   <= {res_24[OVF_SHIFT-1:0], {SHIFT{1'b0}}};
                        quot_reg    <= '0;
                        count_reg   <= CNT_START;
                        if (in_zero || in_ovf) begin
                            op2_reg      <= QUOT_SAT;
                            rem16_reg    <= '0;
                            div_zero_reg <= in_zero;
                            ovf_reg      <= ~in_zero;
                            op_valid_reg <= 1'b1;
                        end
                    end
                end
                DIV: begin
                    rem_reg   <= step_rem;
                    shift_reg <= {shift_reg[IP2WRDLEN-2:0], 1'b0};
                    quot_reg  <= {quot_reg[IP2WRDLEN-2:0], step_q};
                    count_reg <= count_reg - CNTLEN'(1);
                    if (count_reg == '0) begin
                        op2_reg      <= {quot_reg[IP2WRDLEN-2:0], step_q};
                        rem16_reg    <= step_rem[IP1WRDLEN-1:0];
                        div_zero_reg <= 1'b0;
                        ovf_reg      <= 1'b0;
                        op_valid_reg <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = (state_reg != IDLE);
    assign op_valid = op_valid_reg;
    assign op2_32   = op2_reg;
    assign rem_16   = rem16_reg;
    assign div_zero = div_zero_reg;
    assign ovf      = ovf_reg;

endmodule

// File: tb/tb_div24_16.sv
// Directed and randomised checks of the 24/16 -> 32 divider: latency, results,
// error saturation, busy/start handling and mid-operation reset.
module tb_div24_16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [23:0] res_24;
    logic [15:0] op1_16;
    logic        busy;
    logic        op_valid;
    logic [31:0] op2_32;
    logic [15:0] rem_16;
    logic        div_zero;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    div24_16 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .res_24   (res_24),
        .op1_16   (op1_16),
        .busy     (busy),
        .op_valid (op_valid),
        .op2_32   (op2_32),
        .rem_16   (rem_16),
        .div_zero (div_zero),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge (E0), then waits for op_valid; lat counts edges
    // after E0, capped at 40.
    task automatic run_op(input logic [23:0] r, input logic [15:0] d, output int lat);
        res_24 = r;
        op1_16 = d;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        lat    = 0;
        while (!op_valid && lat < 40) begin
            tick();
            lat++;
        end
        $display("op res=%h div=%h -> q=%h r=%h dz=%b ovf=%b lat=%0d",
                 r, d, op2_32, rem_16, div_zero, ovf, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        res_24 = '0;
        op1_16 = '0;
        tick();
        tick();
        n_checks++;
        if ({busy, op_valid, div_zero, ovf} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 0000", {busy, op_valid, div_zero, ovf});
        end
        n_checks++;
        if (op2_32 !== 32'h0 || rem_16 !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_data got q=%h r=%h want 0/0", op2_32, rem_16);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_normal(input logic [23:0] r, input logic [15:0] d,
                               input logic [31:0] exp_q, input logic [15:0] exp_r);
        int lat;
        run_op(r, d, lat);
        n_checks++;
        if (lat !== 32) begin
            n_fail++;
            $display("FAIL norm_latency got %0d want 32", lat);
        end
        n_checks++;
        if (op2_32 !== exp_q || rem_16 !== exp_r) begin
            n_fail++;
            $display("FAIL norm_result got q=%h r=%h want q=%h r=%h", op2_32, rem_16, exp_q, exp_r);
        end
        n_checks++;
        if ({busy, div_zero, ovf} !== 3'b100) begin
            n_fail++;
            $display("FAIL norm_flags got busy/dz/ovf=%b want 100", {busy, div_zero, ovf});
        end
        tick();
        n_checks++;
        if ({busy, op_valid} !== 2'b00 || op2_32 !== exp_q) begin
            n_fail++;
            $display("FAIL norm_hold got busy/valid=%b q=%h want 00 q=%h", {busy, op_valid}, op2_32, exp_q);
        end
    endtask

    task automatic test_ovf();
        int lat;
        run_op(24'hFFFFFF, 16'h0001, lat);
        n_checks++;
        if (lat !== 0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_latency got lat=%0d busy=%b want 0/1", lat, busy);
        end
        n_checks++;
        if ({div_zero, ovf} !== 2'b01 || op2_32 !== 32'hFFFFFFFF || rem_16 !== 16'h0) begin
            n_fail++;
            $display("FAIL ovf_result got dz/ovf=%b q=%h r=%h want 01 ffffffff 0000",
                     {div_zero, ovf}, op2_32, rem_16);
        end
        tick();
        // Exact threshold res == div<<10 must overflow.
        run_op(24'h040000, 16'h0100, lat);
        n_checks++;
        if (lat !== 0 || {div_zero, ovf} !== 2'b01 || op2_32 !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL ovf_boundary got lat=%0d dz/ovf=%b q=%h want 0 01 ffffffff",
                     lat, {div_zero, ovf}, op2_32);
        end
        tick();
    endtask

    task automatic test_div_zero();
        int lat;
        run_op(24'h123456, 16'h0000, lat);
        n_checks++;
        if (lat !== 0) begin
            n_fail++;
            $display("FAIL dz_latency got %0d want 0", lat);
        end
        n_checks++;
        if ({div_zero, ovf} !== 2'b10 || op2_32 !== 32'hFFFFFFFF || rem_16 !== 16'h0) begin
            n_fail++;
            $display("FAIL dz_result got dz/ovf=%b q=%h r=%h want 10 ffffffff 0000",
                     {div_zero, ovf}, op2_32, rem_16);
        end
        tick();
        // res == 0 with div 0 would also meet the overflow test; div_zero wins.
        run_op(24'h000000, 16'h0000, lat);
        n_checks++;
        if ({div_zero, ovf} !== 2'b10) begin
            n_fail++;
            $display("FAIL dz_priority got dz/ovf=%b want 10", {div_zero, ovf});
        end
        tick();
    endtask

    task automatic test_ignore_start();
        int pulses;
        int lat;
        res_24 = 24'h400000;
        op1_16 = 16'h8000;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        res_24 = 24'h000003;
        op1_16 = 16'h0007;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        res_24 = 24'hFFFFFF;
        op1_16 = 16'h0000;
        lat = 10;
        pulses = 0;
        while (!op_valid && lat < 40) begin
            tick();
            lat++;
        end
        $display("op (busy-start ignored) -> q=%h r=%h lat=%0d", op2_32, rem_16, lat);
        n_checks++;
        if (lat !== 32 || op2_32 !== 32'h20000000 || rem_16 !== 16'h0) begin
            n_fail++;
            $display("FAIL busy_start got lat=%0d q=%h r=%h want 32 20000000 0000", lat, op2_32, rem_16);
        end
        // Start during the DONE cycle must be dropped as well.
        res_24 = 24'h000003;
        op1_16 = 16'h0007;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (op_valid) pulses++;
            tick();
        end
        n_checks++;
        if (pulses !== 0 || busy !== 1'b0 || op2_32 !== 32'h20000000) begin
            n_fail++;
            $display("FAIL done_start got pulses=%0d busy=%b q=%h want 0 0 20000000", pulses, busy, op2_32);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        int lat;
        res_24 = 24'h000003;
        op1_16 = 16'h0007;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({busy, op_valid, div_zero, ovf} !== 4'b0000 || op2_32 !== 32'h0 || rem_16 !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_reset got flags=%b q=%h r=%h want 0000 0 0",
                     {busy, op_valid, div_zero, ovf}, op2_32, rem_16);
        end
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (op_valid) pulses++;
            tick();
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_valid got %0d pulses want 0", pulses);
        end
        run_op(24'h000003, 16'h0007, lat);
        n_checks++;
        if (lat !== 32 || op2_32 !== 32'h001B6DB6 || rem_16 !== 16'h0006) begin
            n_fail++;
            $display("FAIL after_reset got lat=%0d q=%h r=%h want 32 001b6db6 0006", lat, op2_32, rem_16);
        end
        tick();
    endtask

    task automatic test_random();
        logic [23:0] r;
        logic [15:0] d;
        logic [63:0] dvd;
        logic [63:0] eq;
        logic [63:0] er;
        logic        eovf;
        int          lat;
        for (int k = 0; k < 24; k++) begin
            r = 24'($urandom);
            d = (k < 8) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(256, 65535));
            dvd  = {40'h0, r} << 22;
            eovf = (dvd >= ({48'h0, d} << 32));
            eq   = dvd / {48'h0, d};
            er   = dvd % {48'h0, d};
            run_op(r, d, lat);
            n_checks++;
            if (eovf) begin
                if (ovf !== 1'b1 || op2_32 !== 32'hFFFFFFFF || rem_16 !== 16'h0 || lat !== 0) begin
                    n_fail++;
                    $display("FAIL rand_ovf res=%h div=%h got ovf=%b q=%h r=%h lat=%0d want 1 ffffffff 0000 0",
                             r, d, ovf, op2_32, rem_16, lat);
                end
            end else begin
                if (ovf !== 1'b0 || op2_32 !== eq[31:0] || rem_16 !== er[15:0] || lat !== 32
                    || ({32'h0, op2_32} * {48'h0, d} + {48'h0, rem_16}) !== dvd
                    || rem_16 >= d) begin
                    n_fail++;
                    $display("FAIL rand_div res=%h div=%h got q=%h r=%h ovf=%b lat=%0d want q=%h r=%h",
                             r, d, op2_32, rem_16, ovf, lat, eq[31:0], er[15:0]);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_normal(24'h400000, 16'h8000, 32'h20000000, 16'h0000);
        test_normal(24'h000003, 16'h0007, 32'h001B6DB6, 16'h0006);
        // Just below the overflow threshold: largest representable quotient.
        test_normal(24'h03FFFF, 16'h0100, 32'hFFFFC000, 16'h0000);
        test_ovf();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
